grad_batch_accumulator: RTL and testbench
=========================================

// Module: grad_batch_accumulator
// PURPOSE
//  Sits directly upstream of the sgd stage.
//  - Accepts one flattened per-sample gradient vector {dL_dw, dL_db} per handshake.
//  - Sums 2**LOG2_BATCH samples in widened accumulators.
//  - Presents the mini-batch mean gradient, held on a valid/ready output, for the sgd grads inputs.
//  - Data format: signed Q8.8 throughout, identical to the sgd datapath.
// PARAMETERS
//  NUM_PARAMS  13  total weights+biases, flattened (2-3-1 net: 9 weights + 4 biases)
//  LOG2_BATCH  2   log2 of mini-batch size; batch = 1<<LOG2_BATCH; legal range 0..8
// PORTS
//  clk        in   1              single clock; all state on rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              in_grad carries a sample gradient
//  in_ready   out  1              block can accept a sample this cycle
//  in_grad    in   NUM_PARAMS*16  per-sample gradient, element i at [i*16 +: 16], signed Q8.8
//  out_valid  out  1              out_grad holds a completed batch mean
//  out_ready  in   1              downstream (sgd update control) consumes out_grad
//  out_grad   out  NUM_PARAMS*16  batch-mean gradient, same packing as in_grad
//  sample_cnt out  LOG2_BATCH+1   samples accepted into the current batch
// BEHAVIOUR
//  Reset: rst sampled high at a clock edge forces the following, regardless of state:
//  - state=ACCUM; all accumulators=0; sample_cnt=0.
//  - out_valid=0; out_grad=0; in_ready=1 on the next cycle.
//  - Any partial batch is discarded; no output is produced for it.
//  State machine (2 states):
//  - ACCUM: in_ready=1, out_valid=0.
//    - Accept = in_valid & in_ready.
//    - On accept with sample_cnt < BATCH-1: acc[i] += sext(in_grad[i]); sample_cnt++.
//    - On accept with sample_cnt == BATCH-1 (final sample):
//      - out_grad[i] = (acc[i] + sext(in_grad[i])) >>> LOG2_BATCH.
//      - Accumulators and sample_cnt clear to 0; state -> OUT.
//    - in_valid=0: hold all state.
//  - OUT: in_ready=0, out_valid=1.
//    - out_grad is registered and must stay stable until out_valid & out_ready.
//    - On out_ready: out_valid=0, state -> ACCUM; out_grad keeps its last value.
//  Latency and throughput:
//  - out_valid rises the cycle after the final-sample accept.
//  - No input is taken in the cycle out_ready is seen: in_ready is driven from state, not from out_ready.
//  - Batch throughput is therefore BATCH accepts + at least 1 output cycle.
//  Arithmetic:
//  - ACC_W = 16 + LOG2_BATCH; inputs sign-extended to ACC_W.
//  - The sum of BATCH Q8.8 values cannot overflow ACC_W, so no saturation is needed.
//  - Mean = arithmetic shift right by LOG2_BATCH (floor, round toward -inf), then the low 16 bits.
//  - The result always fits the 16-bit signed range.
//  - LOG2_BATCH=0: pass-through register; every accept goes straight to OUT.
//  Boundaries:
//  - in_valid asserted while in OUT: ignored; upstream must hold its data.
//  - out_ready asserted while in ACCUM: ignored.
//  - rst concurrent with accept or with output handshake: reset wins.
// STRUCTURE
//  Shared header nn_defs.vh:
//  - DATA_W=16, FRAC_BITS=8.
//  - State encodings ST_ACCUM=1'b0, ST_OUT=1'b1.
//  Sub-module grad_acc_lane (one per element, via generate loop), ports:
//  - clk, rst, clr, add_en, in[15:0], last, mean_out[15:0].
//  - Holds one ACC_W accumulator plus the mean computation.
//  Top level holds the FSM, sample_cnt, handshake logic and the out_grad register.
// TESTING
//  1. BATCH=4; 4 samples, all elements 0x0100 (1.0) -> out_valid 1 cycle after 4th accept;
//     every element 0x0100; sample_cnt back to 0.
//  2. 4 samples, all elements 0xFFFF (-1 LSB) -> every element 0xFFFF.
//     Then samples {1,0,0,0} -> 0x0000; samples {-1,0,0,0} -> 0xFFFF (floor).
//  3. Extremes: 4 samples of 0x7FFF -> 0x7FFF; 4 samples of 0x8000 -> 0x8000; no wrap.
//  4. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 ->
//     out_grad stable, in_ready=0, sample_cnt=0.
//     Then pulse out_ready -> ACCUM next cycle; new batch counts from the first subsequent accept.
//  5. Reset mid-batch: accept 2 samples of 0x0400, assert rst 1 cycle, then 4 samples of 0x0100 ->
//     mean 0x0100, not 0x0300.
//  6. Gapped input: 4 samples with in_valid idle 0-3 random cycles between them,
//     per-element random values -> out_grad matches a floor(sum/4) reference model;
//     exactly one output per 4 accepts.

Source files
------------

// File: rtl/grad_batch_accumulator_pkg.sv
// Shared definitions for the mini-batch gradient accumulator: Q8.8 data format
// and the two FSM state encodings.
package grad_batch_accumulator_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAC_BITS = 8;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_OUT   = 1'b1;

   // Width of an accumulator summing 2**log2_batch Q8.8 samples without overflow.
   function automatic int acc_width(input int log2_batch);
      return DATA_W + log2_batch;
   endfunction

endpackage

// File: rtl/grad_batch_accumulator_lane.sv
// One gradient element: widened signed accumulator plus the floor mean of the
// running sum including the sample currently presented.
module grad_acc_lane
   import grad_batch_accumulator_pkg::*;
#(
   parameter int LOG2_BATCH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              add_en,
   input  logic [DATA_W-1:0] in,
   input  logic              last,
   output logic [DATA_W-1:0] mean_out
);

   localparam int ACC_W = acc_width(LOG2_BATCH);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] in_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] shifted;

   // Sign-extend the sample, add it to the running sum and take the floor mean.
   always_comb begin
      in_ext   = ACC_W'($signed(in));
      sum      = acc + in_ext;
      shifted  = sum >>> LOG2_BATCH;
      mean_out = shifted[DATA_W-1:0];
   end

   // Accumulate non-final samples; the final sample clears for the next batch.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (add_en && !last) begin
         acc <= sum;
      end else begin
         acc <= acc;
      end
   end

endmodule

// File: rtl/grad_batch_accumulator.sv
// Mini-batch gradient accumulator: sums 2**LOG2_BATCH Q8.8 gradient vectors and
// holds their floor mean on a valid/ready output for the sgd stage.
module grad_batch_accumulator
   import grad_batch_accumulator_pkg::*;
#(
   parameter int NUM_PARAMS = 13,
   parameter int LOG2_BATCH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_PARAMS*DATA_W-1:0] in_grad,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_PARAMS*DATA_W-1:0] out_grad,
   output logic [LOG2_BATCH:0]          sample_cnt
);

   localparam logic [LOG2_BATCH:0] CNT_ONE  = (LOG2_BATCH + 1)'(1);
   localparam logic [LOG2_BATCH:0] CNT_LAST = (LOG2_BATCH + 1)'((1 << LOG2_BATCH) - 1);

   logic [0:0]                   state;
   logic                         accept;
   logic                         last;
   logic                         final_accept;
   logic [NUM_PARAMS*DATA_W-1:0] mean_all;

   // Handshake flags come straight from the state register, never from out_ready.
   always_comb begin
      in_ready     = (state == ST_ACCUM);
      out_valid    = (state == ST_OUT);
      accept       = in_valid & in_ready;
      last         = (sample_cnt == CNT_LAST);
      final_accept = accept & last;
   end

   for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_lane
      grad_acc_lane #(
         .LOG2_BATCH (LOG2_BATCH)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (final_accept),
         .add_en   (accept),
         .in       (in_grad[i*DATA_W +: DATA_W]),
         .last     (last),
         .mean_out (mean_all[i*DATA_W +: DATA_W])
      );
   end

   // FSM, sample counter and the held output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_ACCUM;
         sample_cnt <= '0;
         out_grad   <= '0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (final_accept) begin
                  state      <= ST_OUT;
                  sample_cnt <= '0;
                  out_grad   <= mean_all;
               end else if (accept) begin
                  sample_cnt <= sample_cnt + CNT_ONE;
               end else begin
                  sample_cnt <= sample_cnt;
               end
            end
            ST_OUT: begin
               // out_grad keeps its value after the handshake.
               if (out_ready) begin
                  state <= ST_ACCUM;
               end else begin
                  state <= ST_OUT;
               end
            end
            default: begin
               state      <= ST_ACCUM;
               sample_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grad_batch_accumulator.sv
// Directed self-checking bench for grad_batch_accumulator with BATCH=4.
module tb_grad_batch_accumulator;

   localparam int NP = 13;
   localparam int LB = 2;
   localparam int W  = NP * 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_grad = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_grad;
   logic [LB:0]   sample_cnt;

   int checks = 0;
   int errors = 0;

   grad_batch_accumulator #(.NUM_PARAMS(NP), .LOG2_BATCH(LB)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_grad    (in_grad),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_grad   (out_grad),
      .sample_cnt (sample_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] fill(input logic [15:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < NP; i++) r[i*16 +: 16] = v;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One accepted sample: drive, clock, sample #1 after the edge.
   task automatic send(input logic [W-1:0] v);
      in_valid = 1'b1;
      in_grad  = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("consume_out_valid", W'(out_valid), W'(1'b0));
      chk("consume_in_ready", W'(in_ready), W'(1'b1));
   endtask

   task automatic batch_same(input string tag, input logic [15:0] v, input logic [15:0] mean);
      for (int k = 0; k < 4; k++) send(fill(v));
      chk({tag, "_valid"}, W'(out_valid), W'(1'b1));
      chk({tag, "_grad"}, out_grad, fill(mean));
      chk({tag, "_cnt"}, W'(sample_cnt), W'(0));
   endtask

   int           sum [NP];
   logic [15:0]  e;
   logic [W-1:0] v;
   logic [W-1:0] exp_grad;
   logic [W-1:0] held;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", W'(in_ready), W'(1'b1));
      chk("rst_out_valid", W'(out_valid), W'(1'b0));
      chk("rst_out_grad", out_grad, '0);
      chk("rst_cnt", W'(sample_cnt), W'(0));

      // 1: all 1.0, with counter progress and one-cycle latency
      for (int k = 0; k < 3; k++) begin
         send(fill(16'h0100));
         chk("t1_cnt_progress", W'(sample_cnt), W'(k + 1));
         chk("t1_no_early_valid", W'(out_valid), W'(1'b0));
      end
      send(fill(16'h0100));
      chk("t1_valid", W'(out_valid), W'(1'b1));
      chk("t1_in_ready", W'(in_ready), W'(1'b0));
      chk("t1_grad", out_grad, fill(16'h0100));
      chk("t1_cnt", W'(sample_cnt), W'(0));
      consume();
      chk("t1_grad_kept", out_grad, fill(16'h0100));

      // 2: -1 LSB, then floor behaviour
      batch_same("t2_neg", 16'hFFFF, 16'hFFFF);
      consume();
      send(fill(16'h0001)); send(fill(16'h0000)); send(fill(16'h0000)); send(fill(16'h0000));
      chk("t2_pos_floor", out_grad, fill(16'h0000));
      consume();
      send(fill(16'hFFFF)); send(fill(16'h0000)); send(fill(16'h0000)); send(fill(16'h0000));
      chk("t2_neg_floor", out_grad, fill(16'hFFFF));
      consume();

      // 3: extremes
      batch_same("t3_max", 16'h7FFF, 16'h7FFF);
      consume();
      batch_same("t3_min", 16'h8000, 16'h8000);

      // 4: backpressure with in_valid held high in OUT
      in_valid = 1'b1;
      in_grad  = fill(16'h1234);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk("t4_hold_grad", out_grad, fill(16'h8000));
         chk("t4_hold_in_ready", W'(in_ready), W'(1'b0));
         chk("t4_hold_cnt", W'(sample_cnt), W'(0));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("t4_back_accum", W'(in_ready), W'(1'b1));
      chk("t4_no_take", W'(sample_cnt), W'(0));
      @(posedge clk);
      #1;
      chk("t4_first_accept", W'(sample_cnt), W'(1));
      in_valid = 1'b0;
      send(fill(16'h1234)); send(fill(16'h1234)); send(fill(16'h1234));
      chk("t4_grad", out_grad, fill(16'h1234));
      consume();

      // 5: reset mid-batch discards the partial sum
      send(fill(16'h0400)); send(fill(16'h0400));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_rst_cnt", W'(sample_cnt), W'(0));
      chk("t5_rst_grad", out_grad, '0);
      batch_same("t5", 16'h0100, 16'h0100);

      // Reset wins over a pending output
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b0;
      chk("t5_rst_out_valid", W'(out_valid), W'(1'b0));
      chk("t5_rst_out_grad", out_grad, '0);

      // 6: gapped random samples against a floor(sum/4) model
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < NP; i++) sum[i] = 0;
         for (int s = 0; s < 4; s++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
               e = 16'($urandom_range(0, 65535));
               v[i*16 +: 16] = e;
               sum[i] += int'($signed(e));
            end
            send(v);
            chk("t6_one_output_per_4", W'(out_valid), W'(s == 3));
         end
         for (int i = 0; i < NP; i++) exp_grad[i*16 +: 16] = 16'(sum[i] >>> 2);
         chk("t6_grad", out_grad, exp_grad);
         held = out_grad;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         chk("t6_stable", out_grad, held);
         consume();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
